// File: rtl/controller_link_tx.sv
// ---------------------------------------------------------------------------
// controller_link_tx
//
// Controller-side serializer for the 2-wire controller link (chip_clk /
// chip_data). On an accepted send request it snapshots the button bitmap and
// the joystick X/Y bytes. It then shifts out a framed packet MSB first:
//     {HEADER, buttons, joystick_x, joystick_y [, checksum]}
// The link is source-clocked. The receiver samples chip_data on the rising
// edge of chip_clk, and chip_data only ever changes while chip_clk is low.
//
// Build option:
//   CTRL_TX_CHECKSUM_EN  when defined, a fifth byte is appended. It is the
//                        8-bit sum (buttons + jx + jy), with carries dropped.
//                        When undefined, the frame is 4 bytes long.
//
// Parameters:
//   CLK_DIV     clk_in cycles per half bit period (>=2)
//   GAP_CYCLES  idle cycles after the done pulse, before busy_out drops
//   HEADER      sync byte sent first in every frame
//
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous active-high reset
//   send_in        frame request, sampled only while busy_out=0
//   buttons_in     button bitmap      (snapshotted on accept)
//   joystick_x_in  joystick X         (snapshotted on accept)
//   joystick_y_in  joystick Y         (snapshotted on accept)
//   chip_clk_out   link clock
//   chip_data_out  link data
//   busy_out       high from the cycle after accept until the end of the gap
//   done_out       one-cycle pulse after the last bit's high half completes
// ---------------------------------------------------------------------------
module controller_link_tx #(
    parameter int          CLK_DIV    = 4,
    parameter int          GAP_CYCLES = 64,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       send_in,
    input  logic [7:0] buttons_in,
    input  logic [7:0] joystick_x_in,
    input  logic [7:0] joystick_y_in,
    output logic       chip_clk_out,
    output logic       chip_data_out,
    output logic       busy_out,
    output logic       done_out
);

`ifdef CTRL_TX_CHECKSUM_EN
    localparam int NBYTES = 5;
`else
    localparam int NBYTES = 4;
`endif
    localparam int NB     = 8 * NBYTES;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);
    localparam logic [5:0]       BIT_TOP  = 6'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NB-1:0]     shift_q, shift_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              chip_clk_q, chip_clk_d;
    logic              chip_data_q, chip_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Frame assembled from the live inputs. It is only captured on the accept
    // cycle, so input changes during a frame never reach the wire.
    logic [NB-1:0]     frame_w;

`ifdef CTRL_TX_CHECKSUM_EN
    logic [7:0]        chk_w;
    assign chk_w   = buttons_in + joystick_x_in + joystick_y_in;
    assign frame_w = {HEADER, buttons_in, joystick_x_in, joystick_y_in, chk_w};
`else
    assign frame_w = {HEADER, buttons_in, joystick_x_in, joystick_y_in};
`endif

    // The divider wraps on its last count in both half-phases, so every
    // half period is exactly CLK_DIV cycles. There is no drift across bits.
    logic div_wrap_w;
    assign div_wrap_w = (div_q == DIV_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            chip_clk_q  <= 1'b0;
            chip_data_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            chip_clk_q  <= chip_clk_d;
            chip_data_q <= chip_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (send_in)    state_d = S_LOW;
            S_LOW:  if (div_wrap_w) state_d = S_HIGH;
            S_HIGH: if (div_wrap_w) state_d = (bit_cnt_q == 6'd0) ? S_GAP : S_LOW;
            S_GAP:  if (gap_q == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values.
    // Outputs are registered: each value is computed here and appears on
    // the wire the cycle after the deciding edge.
    // ------------------------------------------------------------------
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        gap_d       = gap_q;
        chip_clk_d  = chip_clk_q;
        chip_data_d = chip_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                chip_clk_d  = 1'b0;
                chip_data_d = 1'b0;
                busy_d      = 1'b0;
                if (send_in) begin
                    shift_d     = frame_w;
                    bit_cnt_d   = BIT_TOP;
                    div_d       = '0;
                    gap_d       = '0;
                    chip_data_d = frame_w[NB-1];
                    busy_d      = 1'b1;
                end
            end

            S_LOW: begin
                div_d = div_wrap_w ? '0 : div_q + 1'b1;
                if (div_wrap_w) begin
                    chip_clk_d = 1'b1;
                end
            end

            S_HIGH: begin
                div_d = div_wrap_w ? '0 : div_q + 1'b1;
                if (div_wrap_w) begin
                    // The clock falls on the same edge that the data moves.
                    // The receiver therefore never sees data change while
                    // chip_clk is high.
                    chip_clk_d = 1'b0;
                    if (bit_cnt_q != 6'd0) begin
                        shift_d     = shift_q << 1;
                        chip_data_d = shift_q[NB-2];
                        bit_cnt_d   = bit_cnt_q - 6'd1;
                    end else begin
                        chip_data_d = 1'b0;
                        done_d      = 1'b1;
                        gap_d       = '0;
                    end
                end
            end

            S_GAP: begin
                // The done-pulse cycle is followed by GAP_CYCLES idle
                // cycles. Only after those does busy drop.
                if (gap_q == GAP_LAST) begin
                    busy_d = 1'b0;
                    gap_d  = '0;
                end else begin
                    gap_d  = gap_q + 1'b1;
                end
            end

            default: begin
                chip_clk_d  = 1'b0;
                chip_data_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign chip_clk_out  = chip_clk_q;
    assign chip_data_out = chip_data_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;

endmodule

// File: tb/tb_controller_link_tx.sv
module tb_controller_link_tx;

`ifdef CTRL_TX_CHECKSUM_EN
    localparam int NB = 40;
    localparam logic [NB-1:0] F1  = 40'hA501807F00;
    localparam logic [NB-1:0] F3  = 40'hA53C55AA3B;
    localparam logic [NB-1:0] F4A = 40'hA500123446;
    localparam logic [NB-1:0] F4B = 40'hA5FF123445;
    localparam logic [NB-1:0] F5  = 40'hA5814002C3;
`else
    localparam int NB = 32;
    localparam logic [NB-1:0] F1  = 32'hA501807F;
    localparam logic [NB-1:0] F3  = 32'hA53C55AA;
    localparam logic [NB-1:0] F4A = 32'hA5001234;
    localparam logic [NB-1:0] F4B = 32'hA5FF1234;
    localparam logic [NB-1:0] F5  = 32'hA5814002;
`endif
    localparam int CLK_DIV = 4;
    localparam int GAP     = 64;
    localparam int T_DONE  = 1 + NB * 2 * CLK_DIV;
    localparam int T_FREE  = T_DONE + 1 + GAP;
    localparam int LIM     = T_FREE + 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic [7:0] jx = 8'h00;
    logic [7:0] jy = 8'h00;
    logic       chip_clk, chip_data, busy, done;

    int errors = 0;
    int checks = 0;

    controller_link_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP),
        .HEADER     (8'hA5)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .send_in       (send),
        .buttons_in    (buttons),
        .joystick_x_in (jx),
        .joystick_y_in (jy),
        .chip_clk_out  (chip_clk),
        .chip_data_out (chip_data),
        .busy_out      (busy),
        .done_out      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame and follows it cycle by cycle.
    // It checks the bit stream, the phase lengths, data stability, the done
    // time and the busy-fall time.
    //   chg_bit   : after this many clk rises, buttons change to FF (0 = never)
    //   pulse_bit : after this many clk rises, send is pulsed for one cycle (0 = never)
    //   hold      : keep send high throughout; expect an immediate re-accept
    task automatic run_frame(input string name, input logic [NB-1:0] exp_frame,
                             input int chg_bit, input int pulse_bit, input bit hold);
        logic [NB-1:0] cap;
        int  rises, run, done_t, done_cnt, busy_fall, pulse_clr;
        logic prev_clk, prev_data;
        cap = '0; rises = 0; run = 0; done_t = -1; done_cnt = 0;
        busy_fall = -1; pulse_clr = -1;
        prev_clk = chip_clk; prev_data = chip_data;
        send = 1'b1;
        for (int t = 1; t <= LIM; t++) begin
            tick();
            if (t == 1) begin
                if (!hold) send = 1'b0;
                check_eq({name, "_busy_rise"}, 64'(busy), 64'd1);
                check_eq({name, "_first_bit"}, 64'(chip_data), 64'(exp_frame[NB-1]));
            end
            if (t == pulse_clr) send = 1'b0;
            if (chip_data !== prev_data)
                check_eq({name, "_data_stable"}, 64'(chip_clk), 64'd0);
            if (chip_clk === 1'b1 && prev_clk === 1'b0) begin
                if (rises == 0) check_eq({name, "_first_rise_t"}, 64'(t), 64'(CLK_DIV + 1));
                else            check_eq({name, "_low_len"}, 64'(run), 64'(CLK_DIV));
                cap = {cap[NB-2:0], chip_data};
                rises++;
                run = 1;
                if (rises == chg_bit) buttons = 8'hFF;
                if (rises == pulse_bit) begin
                    send = 1'b1;
                    pulse_clr = t + 1;
                end
            end else if (chip_clk === 1'b0 && prev_clk === 1'b1) begin
                check_eq({name, "_high_len"}, 64'(run), 64'(CLK_DIV));
                run = 1;
            end else begin
                run++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_t < 0) begin
                    done_t = t;
                    check_eq({name, "_gap_lines_low"}, 64'({chip_clk, chip_data}), 64'd0);
                end
            end
            prev_clk = chip_clk;
            prev_data = chip_data;
            if (busy === 1'b0) begin
                busy_fall = t;
                break;
            end
        end
        check_eq({name, "_rises"}, 64'(rises), 64'(NB));
        check_eq({name, "_frame"}, 64'(cap), 64'(exp_frame));
        check_eq({name, "_done_t"}, 64'(done_t), 64'(T_DONE));
        check_eq({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check_eq({name, "_busy_fall_t"}, 64'(busy_fall), 64'(T_FREE));
        if (hold) begin
            tick();
            check_eq({name, "_reaccept"}, 64'(busy), 64'd1);
            check_eq({name, "_reaccept_bit"}, 64'(chip_data), 64'(exp_frame[NB-1]));
        end else begin
            repeat (3) tick();
            check_eq({name, "_no_requeue"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        check_eq("rst_clk",  64'(chip_clk),  64'd0);
        check_eq("rst_data", 64'(chip_data), 64'd0);
        check_eq("rst_busy", 64'(busy),      64'd0);
        check_eq("rst_done", 64'(done),      64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic frame, checksum wraps to 00; a mid-frame pulse is dropped
        buttons = 8'h01; jx = 8'h80; jy = 8'h7F;
        run_frame("t1", F1, 0, 15, 1'b0);

        // send held high: back-to-back frames with a single accept cycle
        buttons = 8'h3C; jx = 8'h55; jy = 8'hAA;
        run_frame("t3", F3, 0, 0, 1'b1);
        send = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < LIM) begin
            tick();
            n++;
        end
        check_eq("t3_second_len", 64'(n), 64'(T_FREE - 1));
        repeat (2) tick();

        // Input change mid-frame does not affect the frame in flight
        buttons = 8'h00; jx = 8'h12; jy = 8'h34;
        run_frame("t4a", F4A, 12, 0, 1'b0);
        run_frame("t4b", F4B, 0, 0, 1'b0);

        // Asynchronous reset mid-HIGH of bit 20
        buttons = 8'h11; jx = 8'h22; jy = 8'h33;
        send = 1'b1;
        tick();
        send = 1'b0;
        n = 0;
        for (int t = 0; t < LIM && n < 20; t++) begin
            logic pc;
            pc = chip_clk;
            tick();
            if (pc === 1'b0 && chip_clk === 1'b1) n++;
        end
        check_eq("t5_reached_bit20", 64'(n), 64'd20);
        tick();
        check_eq("t5_in_high", 64'(chip_clk), 64'd1);
        #3 rst = 1'b1;
        #1;
        check_eq("t5_async_clk",  64'(chip_clk),  64'd0);
        check_eq("t5_async_data", 64'(chip_data), 64'd0);
        check_eq("t5_async_busy", 64'(busy),      64'd0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int t = 0; t < 2 * CLK_DIV * 30; t++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        check_eq("t5_no_done_after_abort", 64'(n), 64'd0);
        buttons = 8'h81; jx = 8'h40; jy = 8'h02;
        run_frame("t5", F5, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
